dht22_frame_decoder: RTL

- Sits between the DHT22 sensor controller and the VGA character renderer.
- Accepts each raw 40-bit DHT22 frame with a one-cycle strobe and validates its checksum and range.
- Converts humidity and temperature (tenths units) to 4-digit BCD using a sequential shift-add-3 engine.
- Holds the last good reading for display and keeps error status/counters.

---
 rtl/dht22_frame_decoder.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/dht22_frame_decoder.sv
// DHT22 frame decoder: validates raw 40-bit sensor frames and converts humidity
// and temperature magnitude (tenths units) to 4-digit BCD for the display.
// A frame is captured only while idle, checked for checksum and range, converted
// with a sequential shift-add-3 engine, and committed to the outputs atomically.
//
// Ports:
//   clk_100MHz - system clock
//   rst_n      - asynchronous active-low reset
//   ht_valid   - one-cycle strobe, HT_data valid this cycle
//   HT_data    - raw frame {hum[15:0], sign, temp_mag[14:0], checksum[7:0]}
//   hum_bcd    - humidity digits {hundreds, tens, ones, tenths}
//   temp_bcd   - temperature magnitude digits, same layout
//   temp_neg   - temperature negative (never set for a zero magnitude)
//   data_ok    - sticky, set by the first committed frame
//   upd        - one-cycle pulse when new values are committed
//   chk_err    - one-cycle pulse on checksum mismatch
//   rng_err    - one-cycle pulse on out-of-range value
//   err_cnt    - saturating count of rejected frames
//   busy       - high whenever the FSM is not idle
module dht22_frame_decoder #(
  parameter int unsigned HUM_MAX  = 1000,
  parameter int unsigned TEMP_MAX = 800,
  parameter int unsigned ERR_W    = 8
) (
  input  logic             clk_100MHz,
  input  logic             rst_n,
  input  logic             ht_valid,
  input  logic [39:0]      HT_data,
  output logic [15:0]      hum_bcd,
  output logic [15:0]      temp_bcd,
  output logic             temp_neg,
  output logic             data_ok,
  output logic             upd,
  output logic             chk_err,
  output logic             rng_err,
  output logic [ERR_W-1:0] err_cnt,
  output logic             busy
);

  localparam logic [15:0] HumMax  = 16'(HUM_MAX);
  localparam logic [14:0] TempMax = 15'(TEMP_MAX);

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StConvH,
    StConvT,
    StCommit
  } state_e;

  state_e           state_q, state_d;
  logic [39:0]      frame_q, frame_d;
  logic [15:0]      shift_q, shift_d;
  logic [15:0]      acc_q, acc_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [15:0]      hum_res_q, hum_res_d;
  logic [15:0]      hum_bcd_q, hum_bcd_d;
  logic [15:0]      temp_bcd_q, temp_bcd_d;
  logic             temp_neg_q, temp_neg_d;
  logic             data_ok_q, data_ok_d;
  logic             upd_q, upd_d;
  logic             chk_err_q, chk_err_d;
  logic             rng_err_q, rng_err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  logic [7:0]       csum;
  logic [15:0]      acc_adj;
  logic [15:0]      acc_step;
  logic [ERR_W-1:0] err_cnt_inc;

  assign csum = frame_q[39:32] + frame_q[31:24] + frame_q[23:16] + frame_q[15:8];

  assign err_cnt_inc = (err_cnt_q == {ERR_W{1'b1}}) ? err_cnt_q
                                                     : err_cnt_q + {{(ERR_W-1){1'b0}}, 1'b1};

  // One double-dabble iteration: correct each digit >= 5, then shift in the next value bit.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < 4; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
    acc_step = (acc_adj << 1) | {15'd0, shift_q[15]};
  end

  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    shift_d    = shift_q;
    acc_d      = acc_q;
    bit_cnt_d  = bit_cnt_q;
    hum_res_d  = hum_res_q;
    hum_bcd_d  = hum_bcd_q;
    temp_bcd_d = temp_bcd_q;
    temp_neg_d = temp_neg_q;
    data_ok_d  = data_ok_q;
    err_cnt_d  = err_cnt_q;
    upd_d      = 1'b0;
    chk_err_d  = 1'b0;
    rng_err_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (ht_valid) begin
          frame_d = HT_data;
          state_d = StCheck;
        end
      end
      StCheck: begin
        // Checksum takes priority: a corrupt frame never reports a range error.
        if (csum != frame_q[7:0]) begin
          chk_err_d = 1'b1;
          err_cnt_d = err_cnt_inc;
          state_d   = StIdle;
        end else if ((frame_q[39:24] > HumMax) || (frame_q[22:8] > TempMax)) begin
          rng_err_d = 1'b1;
          err_cnt_d = err_cnt_inc;
          state_d   = StIdle;
        end else begin
          shift_d   = frame_q[39:24];
          acc_d     = '0;
          bit_cnt_d = '0;
          state_d   = StConvH;
        end
      end
      StConvH: begin
        shift_d   = shift_q << 1;
        acc_d     = acc_step;
        bit_cnt_d = bit_cnt_q + 4'd1;
        if (bit_cnt_q == 4'd15) begin
          hum_res_d = acc_step;
          shift_d   = {1'b0, frame_q[22:8]};
          acc_d     = '0;
          state_d   = StConvT;
        end
      end
      StConvT: begin
        shift_d   = shift_q << 1;
        acc_d     = acc_step;
        bit_cnt_d = bit_cnt_q + 4'd1;
        if (bit_cnt_q == 4'd15) begin
          state_d = StCommit;
        end
      end
      StCommit: begin
        // acc_q holds the finished temperature digits here.
        hum_bcd_d  = hum_res_q;
        temp_bcd_d = acc_q;
        temp_neg_d = frame_q[23] & (|frame_q[22:8]);
        data_ok_d  = 1'b1;
        upd_d      = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      frame_q    <= '0;
      shift_q    <= '0;
      acc_q      <= '0;
      bit_cnt_q  <= '0;
      hum_res_q  <= '0;
      hum_bcd_q  <= '0;
      temp_bcd_q <= '0;
      temp_neg_q <= 1'b0;
      data_ok_q  <= 1'b0;
      upd_q      <= 1'b0;
      chk_err_q  <= 1'b0;
      rng_err_q  <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      shift_q    <= shift_d;
      acc_q      <= acc_d;
      bit_cnt_q  <= bit_cnt_d;
      hum_res_q  <= hum_res_d;
      hum_bcd_q  <= hum_bcd_d;
      temp_bcd_q <= temp_bcd_d;
      temp_neg_q <= temp_neg_d;
      data_ok_q  <= data_ok_d;
      upd_q      <= upd_d;
      chk_err_q  <= chk_err_d;
      rng_err_q  <= rng_err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign hum_bcd  = hum_bcd_q;
  assign temp_bcd = temp_bcd_q;
  assign temp_neg = temp_neg_q;
  assign data_ok  = data_ok_q;
  assign upd      = upd_q;
  assign chk_err  = chk_err_q;
  assign rng_err  = rng_err_q;
  assign err_cnt  = err_cnt_q;
  assign busy     = (state_q != StIdle);

endmodule
